// File: rtl/chess_display_if.sv
// Display bus between the countdown stage and the 7-segment scanner:
// player times flow in, multiplexed anode/cathode/dp drive flows out.
interface chess_display_if;
   logic [5:0] min1;
   logic [5:0] seg1;
   logic [5:0] min2;
   logic [5:0] seg2;
   logic [7:0] anode;
   logic [6:0] cathode;
   logic       dp;

   modport master (
      output min1, seg1, min2, seg2,
      input  anode, cathode, dp
   );

   modport slave (
      input  min1, seg1, min2, seg2,
      output anode, cathode, dp
   );
endinterface

// File: rtl/chess_display.sv
// Two-player mm:ss scanner for eight common-anode 7-segment digits.
// Inputs are captured once per frame, split into decimal digits and shown
// one digit per scan step; a player at 00:00 blinks. Outputs active-low.
module chess_display #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   chess_display_if.slave  bus
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   // Field order matches index[2:1]: 0=seg2, 1=min2, 2=seg1, 3=min1
   logic [SCAN_W-1:0]  scan_cnt_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_phase_q;
   logic [2:0]         index_q;
   logic               valid_q;     // set by the first frame start after reset
   logic [5:0]         snap_q [4];
   logic [5:0]         field_in [4];
   logic               tick;

   logic [6:0] tens_code  [4];
   logic [6:0] units_code [4];

   logic [7:0] anode_d,   anode_q;
   logic [6:0] cathode_d, cathode_q;
   logic       dp_d,      dp_q;

   assign tick = (scan_cnt_q == SCAN_LAST);

   assign field_in[0] = bus.seg2;
   assign field_in[1] = bus.min2;
   assign field_in[2] = bus.seg1;
   assign field_in[3] = bus.min1;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = 7'h7F;
      endcase
      return c;
   endfunction

   // Scan prescaler, digit index and once-per-frame input snapshot
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q <= '0;
         index_q    <= 3'd7;
         valid_q    <= 1'b0;
         for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      end else begin
         scan_cnt_q <= tick ? '0 : scan_cnt_q + 1'b1;
         if (tick) begin
            index_q <= index_q + 3'd1;
            if (index_q == 3'd7) begin
               valid_q <= 1'b1;
               for (int i = 0; i < 4; i++) snap_q[i] <= field_in[i];
            end
         end
      end
   end

   // Free-running blink timebase, independent of the scan
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_field
         logic [5:0] v;
         logic [3:0] tens, units;
         assign v = snap_q[gi];

         // Binary 0..59 to two decimal digits; 60..63 shows dashes
         always_comb begin
            tens  = 4'd0;
            units = 4'(v);
            if      (v >= 6'd50) begin tens = 4'd5; units = 4'(v - 6'd50); end
            else if (v >= 6'd40) begin tens = 4'd4; units = 4'(v - 6'd40); end
            else if (v >= 6'd30) begin tens = 4'd3; units = 4'(v - 6'd30); end
            else if (v >= 6'd20) begin tens = 4'd2; units = 4'(v - 6'd20); end
            else if (v >= 6'd10) begin tens = 4'd1; units = 4'(v - 6'd10); end
            if (v >= 6'd60) begin
               tens_code[gi]  = 7'h3F;
               units_code[gi] = 7'h3F;
            end else begin
               tens_code[gi]  = seg7(tens);
               units_code[gi] = seg7(units);
            end
         end
      end
   endgenerate

   // Select the current digit, apply blink blanking on expired players
   always_comb begin
      logic p1_zero, p2_zero;
      anode_d   = 8'hFF;
      cathode_d = 7'h7F;
      dp_d      = 1'b1;
      p1_zero   = (snap_q[3] == 6'd0) && (snap_q[2] == 6'd0);
      p2_zero   = (snap_q[1] == 6'd0) && (snap_q[0] == 6'd0);
      if (valid_q) begin
         anode_d   = ~(8'b1 << index_q);
         cathode_d = index_q[0] ? tens_code[index_q[2:1]] : units_code[index_q[2:1]];
         dp_d      = (index_q[1:0] == 2'b10) ? 1'b0 : 1'b1;
         if (blink_phase_q && p1_zero) anode_d[7:4] = 4'hF;
         if (blink_phase_q && p2_zero) anode_d[3:0] = 4'hF;
      end
   end

   // Output pipeline stage; reset reaches it through valid_q one edge later
   always_ff @(posedge clk) begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
   end

   assign bus.anode   = anode_q;
   assign bus.cathode = cathode_q;
   assign bus.dp      = dp_q;

endmodule

// File: tb/tb_chess_display.sv
// Directed bench for chess_display (SCAN_DIV=4, BLINK_DIV=16). Stimulus pushes
// timed expectations into a scoreboard; a negedge monitor checks each due entry.
module tb_chess_display;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   chess_display_if bus();

   chess_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int unsigned t;
      int          c;
      int          d;
      logic [7:0]  an;
      logic [6:0]  ca;
      logic        dp;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned tcyc  = 0;
   int unsigned t0;

   always @(posedge clk) tcyc <= tcyc + 1;

   // Monitor: compare every expectation whose due cycle has arrived
   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].t <= tcyc) begin
         e = sb_q.pop_front();
         n_cmp++;
         if (e.t != tcyc) begin
            n_bad++;
            $display("FAIL slot c=%0d digit=%0d: missed, now %0d due %0d", e.c, e.d, tcyc, e.t);
         end else if ({bus.anode, bus.cathode, bus.dp} !== {e.an, e.ca, e.dp}) begin
            n_bad++;
            $display("FAIL slot c=%0d digit=%0d: got anode=%h cathode=%h dp=%b, want anode=%h cathode=%h dp=%b",
                     e.c, e.d, bus.anode, bus.cathode, bus.dp, e.an, e.ca, e.dp);
         end else begin
            $display("ok   slot c=%0d digit=%0d anode=%h cathode=%h dp=%b",
                     e.c, e.d, bus.anode, bus.cathode, bus.dp);
         end
      end
   end

   task automatic wait_to(input int unsigned t);
      while (tcyc < t) @(negedge clk);
   endtask

   // Outputs idle for the four edges before the first tick
   task automatic push_reset(input int unsigned tb);
      exp_t e;
      for (int c = 1; c <= 4; c++) begin
         e = '{t: tb + c, c: c, d: -1, an: 8'hFF, ca: 7'h7F, dp: 1'b1};
         sb_q.push_back(e);
      end
   endtask

   // Digit j of frame k first appears 5+32k+4j edges after reset release
   task automatic push_frame(input int unsigned tb, input int k, input logic [55:0] ca,
                             input logic [7:0] blank, input int n);
      exp_t e;
      for (int j = 0; j < n; j++) begin
         e.c  = 5 + 32*k + 4*j;
         e.t  = tb + e.c;
         e.d  = j;
         e.an = blank[j] ? 8'hFF : ~(8'b1 << j);
         e.ca = ca[7*j +: 7];
         e.dp = (j == 2 || j == 6) ? 1'b0 : 1'b1;
         sb_q.push_back(e);
      end
   endtask

   function automatic void set_in(input logic [5:0] m1, input logic [5:0] s1,
                                  input logic [5:0] m2, input logic [5:0] s2);
      bus.min1 = m1; bus.seg1 = s1; bus.min2 = m2; bus.seg2 = s2;
   endfunction

   // Codes listed digit 7 down to digit 0
   localparam logic [55:0] ALL_ZERO = {8{7'h40}};
   localparam logic [55:0] F_12_34  = {7'h79,7'h24,7'h30,7'h19,7'h40,7'h12,7'h40,7'h10};
   localparam logic [55:0] F_SEG8   = {7'h79,7'h24,7'h30,7'h19,7'h40,7'h12,7'h40,7'h00};
   localparam logic [55:0] F_10_00  = {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40};
   localparam logic [55:0] F_DASH   = {7'h79,7'h24,7'h3F,7'h3F,7'h40,7'h12,7'h40,7'h10};

   // The 32-cycle blink period equals the frame, so blink_phase=1 always
   // covers digits 3..6 and phase=0 covers digits 7,0,1,2.
   localparam logic [7:0] PH1_DIGITS = 8'b0111_1000;

   initial begin
      set_in(6'd0, 6'd0, 6'd0, 6'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      t0 = tcyc;

      push_reset(t0);
      push_frame(t0, 0, ALL_ZERO, PH1_DIGITS, 8);

      wait_to(t0 + 6);
      set_in(6'd12, 6'd34, 6'd5, 6'd9);
      push_frame(t0, 1, F_12_34, 8'h00, 8);

      wait_to(t0 + 49);               // index=3 in frame 1
      bus.seg2 = 6'd8;
      push_frame(t0, 2, F_SEG8, 8'h00, 8);

      wait_to(t0 + 70);
      set_in(6'd10, 6'd0, 6'd0, 6'd0);
      push_frame(t0, 3, F_10_00, PH1_DIGITS & 8'h0F, 8);

      wait_to(t0 + 102);
      set_in(6'd12, 6'd60, 6'd5, 6'd9);
      push_frame(t0, 4, F_DASH, 8'h00, 8);
      push_frame(t0, 5, F_DASH, 8'h00, 5);

      wait_to(t0 + 181);              // index=4 in frame 5
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t0 = tcyc;
      push_reset(t0);
      push_frame(t0, 0, F_DASH, 8'h00, 8);

      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
